// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller.
// FSM encoding, timer width and calendar limits.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  localparam int SECS_PER_MIN = 60;
  localparam int TIMER_W      = 9;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;

endpackage

// File: rtl/alarm_sec_timer.sv
// Loadable seconds down-counter; decrements on sec_tick, holds at zero.
// expire flags the tick that takes the count from 1 to 0.
module alarm_sec_timer
  import alarm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               tick,
  output logic               zero,
  output logic               expire
);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero   = (cnt == '0);
  assign expire = tick && (cnt == TIMER_W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: settings registers, match detect, ring/snooze FSM.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [2:0] week,
  input  logic       alarm_set,
  input  logic [4:0] alarm_hour_set,
  input  logic [5:0] alarm_min_set,
  input  logic [6:0] week_mask_set,
  input  logic       arm_set,
  input  logic       stop,
  input  logic       snooze,
  output logic       ring,
  output logic [1:0] state,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic [6:0] week_mask,
  output logic       armed,
  output logic [1:0] snooze_cnt
);

  localparam logic [TIMER_W-1:0] RING_LD = TIMER_W'(RING_SECS);

`ifdef ALARM_SNOOZE_EN
  localparam logic [TIMER_W-1:0] SNZ_LD =
    TIMER_W'(SNOOZE_MIN * SECS_PER_MIN);
`else
  logic unused_snz;
  assign unused_snz = ^{snooze, 2'(MAX_SNOOZE), TIMER_W'(SNOOZE_MIN)};
`endif

  state_t             st, st_n;
  logic [1:0]         cnt_q, cnt_n;
  logic               ld;
  logic [TIMER_W-1:0] ld_val;
  logic               t_zero, t_exp, done;
  logic [6:0]         wk_oh;
  logic               match;

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_hour <= 5'd0;
      alarm_min  <= 6'd0;
      week_mask  <= 7'h7F;
      armed      <= 1'b0;
    end else if (alarm_set) begin
      alarm_hour <= alarm_hour_set;
      alarm_min  <= alarm_min_set;
      week_mask  <= week_mask_set;
      armed      <= arm_set;
    end
  end

  // Out-of-range stored settings can never match.
  assign wk_oh = (week == 3'd0) ? 7'd0 : 7'd1 << (week - 3'd1);
  assign match = sec_tick && armed
              && hour == alarm_hour && min == alarm_min
              && sec == 6'd0
              && alarm_hour <= HOUR_MAX && alarm_min <= MIN_MAX
              && |(wk_oh & week_mask);

  alarm_sec_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .tick     (sec_tick),
    .zero     (t_zero),
    .expire   (t_exp)
  );

  assign done = t_exp || (sec_tick && t_zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= ST_IDLE;
      cnt_q <= 2'd0;
    end else begin
      st    <= st_n;
      cnt_q <= cnt_n;
    end
  end

  always_comb begin
    st_n   = st;
    cnt_n  = cnt_q;
    ld     = 1'b0;
    ld_val = '0;
    if (alarm_set || stop) begin
      st_n  = ST_IDLE;
      cnt_n = 2'd0;
      ld    = 1'b1;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (match) begin
            st_n   = ST_RING;
            cnt_n  = 2'd0;
            ld     = 1'b1;
            ld_val = RING_LD;
          end
        end
        ST_RING: begin
`ifdef ALARM_SNOOZE_EN
          if (snooze && cnt_q < 2'(MAX_SNOOZE)) begin
            st_n   = ST_SNOOZE;
            cnt_n  = cnt_q + 2'd1;
            ld     = 1'b1;
            ld_val = SNZ_LD;
          end else
`endif
          if (done) begin
            st_n = ST_IDLE;
          end
        end
        ST_SNOOZE: begin
          if (done) begin
            st_n   = ST_RING;
            ld     = 1'b1;
            ld_val = RING_LD;
          end
        end
        default: st_n = ST_IDLE;
      endcase
    end
  end

  assign ring       = (st == ST_RING);
  assign state      = st;
  assign snooze_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: expectations queued at drive time,
// popped and compared 1ns after each rising edge.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sec_tick;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [2:0] week;
  logic       alarm_set;
  logic [4:0] alarm_hour_set;
  logic [5:0] alarm_min_set;
  logic [6:0] week_mask_set;
  logic       arm_set;
  logic       stop;
  logic       snooze;
  logic       ring;
  logic [1:0] state;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [6:0] week_mask;
  logic       armed;
  logic [1:0] snooze_cnt;

  alarm_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .sec_tick       (sec_tick),
    .hour           (hour),
    .min            (min),
    .sec            (sec),
    .week           (week),
    .alarm_set      (alarm_set),
    .alarm_hour_set (alarm_hour_set),
    .alarm_min_set  (alarm_min_set),
    .week_mask_set  (week_mask_set),
    .arm_set        (arm_set),
    .stop           (stop),
    .snooze         (snooze),
    .ring           (ring),
    .state          (state),
    .alarm_hour     (alarm_hour),
    .alarm_min      (alarm_min),
    .week_mask      (week_mask),
    .armed          (armed),
    .snooze_cnt     (snooze_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [1:0] st;
    logic       rg;
    logic [1:0] sc;
    bit         cfg;
    logic [4:0] ah;
    logic [5:0] am;
    logic [6:0] wm;
    logic       ar;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_run = 0;
  int   n_fail = 0;
  int   n_id = 0;

  logic [4:0] c_ah;
  logic [5:0] c_am;
  logic [6:0] c_wm;
  logic       c_ar;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      m_e = q.pop_front();
      check_eq($sformatf("state#%0d", m_e.id), 32'(state), 32'(m_e.st));
      check_eq($sformatf("ring#%0d", m_e.id), 32'(ring), 32'(m_e.rg));
      check_eq($sformatf("snz_cnt#%0d", m_e.id),
               32'(snooze_cnt), 32'(m_e.sc));
      if (m_e.cfg) begin
        check_eq($sformatf("a_hour#%0d", m_e.id),
                 32'(alarm_hour), 32'(m_e.ah));
        check_eq($sformatf("a_min#%0d", m_e.id),
                 32'(alarm_min), 32'(m_e.am));
        check_eq($sformatf("mask#%0d", m_e.id),
                 32'(week_mask), 32'(m_e.wm));
        check_eq($sformatf("armed#%0d", m_e.id), 32'(armed), 32'(m_e.ar));
      end
    end
  end

  task automatic expect_out(input logic [1:0] st, input logic rg,
                            input logic [1:0] sc, input bit cfg);
    exp_t e;
    e.id  = n_id;
    e.st  = st;
    e.rg  = rg;
    e.sc  = sc;
    e.cfg = cfg;
    e.ah  = c_ah;
    e.am  = c_am;
    e.wm  = c_wm;
    e.ar  = c_ar;
    n_id++;
    q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input logic [4:0] h, input logic [5:0] m,
                      input logic [6:0] w, input logic a);
    alarm_set      = 1'b1;
    alarm_hour_set = h;
    alarm_min_set  = m;
    week_mask_set  = w;
    arm_set        = a;
    c_ah = h;
    c_am = m;
    c_wm = w;
    c_ar = a;
    expect_out(2'd0, 1'b0, 2'd0, 1'b1);
    step();
    alarm_set = 1'b0;
  endtask

  task automatic tick_at(input logic [4:0] h, input logic [5:0] m,
                         input logic [5:0] s, input logic [2:0] w,
                         input logic [1:0] st, input logic rg,
                         input logic [1:0] sc);
    hour     = h;
    min      = m;
    sec      = s;
    week     = w;
    sec_tick = 1'b1;
    expect_out(st, rg, sc, 1'b0);
    step();
    sec_tick = 1'b0;
    sec      = 6'd5;
  endtask

  task automatic trigger();
    tick_at(5'd7, 6'd30, 6'd0, 3'd3, 2'd1, 1'b1, 2'd0);
  endtask

  // n ticks; check the state after tick n-1 and after tick n.
  task automatic ticks(input int n,
                       input logic [1:0] st_b, input logic rg_b,
                       input logic [1:0] st_a, input logic rg_a,
                       input logic [1:0] sc);
    sec = 6'd5;
    for (int i = 1; i <= n; i++) begin
      sec_tick = 1'b1;
      if (i == n - 1) expect_out(st_b, rg_b, sc, 1'b0);
      if (i == n) expect_out(st_a, rg_a, sc, 1'b0);
      step();
    end
    sec_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sec_tick = 1'b0;
    hour = 5'd0;
    min = 6'd0;
    sec = 6'd5;
    week = 3'd1;
    alarm_set = 1'b0;
    alarm_hour_set = 5'd0;
    alarm_min_set = 6'd0;
    week_mask_set = 7'd0;
    arm_set = 1'b0;
    stop = 1'b0;
    snooze = 1'b0;
    c_ah = 5'd0;
    c_am = 6'd0;
    c_wm = 7'h7F;
    c_ar = 1'b0;

    expect_out(2'd0, 1'b0, 2'd0, 1'b1);
    step();
    rst = 1'b0;

    tick_at(5'd0, 6'd0, 6'd0, 3'd1, 2'd0, 1'b0, 2'd0);

    load(5'd7, 6'd30, 7'h1F, 1'b1);
    tick_at(5'd7, 6'd30, 6'd0, 3'd6, 2'd0, 1'b0, 2'd0);
    tick_at(5'd7, 6'd30, 6'd0, 3'd0, 2'd0, 1'b0, 2'd0);
    tick_at(5'd7, 6'd30, 6'd1, 3'd3, 2'd0, 1'b0, 2'd0);
    tick_at(5'd7, 6'd31, 6'd0, 3'd3, 2'd0, 1'b0, 2'd0);

    trigger();
    ticks(60, 2'd1, 1'b1, 2'd0, 1'b0, 2'd0);

    trigger();
    stop   = 1'b1;
    snooze = 1'b1;
    expect_out(2'd0, 1'b0, 2'd0, 1'b0);
    step();
    stop   = 1'b0;
    snooze = 1'b0;

`ifdef ALARM_SNOOZE_EN
    trigger();
    for (int k = 1; k <= 3; k++) begin
      snooze = 1'b1;
      expect_out(2'd2, 1'b0, 2'(k), 1'b0);
      step();
      snooze = 1'b0;
      ticks(300, 2'd2, 1'b0, 2'd1, 1'b1, 2'(k));
    end
    snooze = 1'b1;
    expect_out(2'd1, 1'b1, 2'd3, 1'b0);
    step();
    snooze = 1'b0;
    stop = 1'b1;
    expect_out(2'd0, 1'b0, 2'd0, 1'b0);
    step();
    stop = 1'b0;
    trigger();
    snooze = 1'b1;
    expect_out(2'd2, 1'b0, 2'd1, 1'b0);
    step();
    snooze = 1'b0;
    load(5'd6, 6'd15, 7'h7F, 1'b0);
`else
    trigger();
    snooze = 1'b1;
    expect_out(2'd1, 1'b1, 2'd0, 1'b0);
    step();
    snooze = 1'b0;
    load(5'd6, 6'd15, 7'h7F, 1'b0);
`endif

    load(5'd24, 6'd0, 7'h7F, 1'b1);
    tick_at(5'd24, 6'd0, 6'd0, 3'd1, 2'd0, 1'b0, 2'd0);
    load(5'd5, 6'd60, 7'h7F, 1'b1);
    tick_at(5'd5, 6'd60, 6'd0, 3'd1, 2'd0, 1'b0, 2'd0);

    load(5'd7, 6'd30, 7'h1F, 1'b1);
    trigger();
    rst = 1'b1;
    c_ah = 5'd0;
    c_am = 6'd0;
    c_wm = 7'h7F;
    c_ar = 1'b0;
    expect_out(2'd0, 1'b0, 2'd0, 1'b1);
    step();
    rst = 1'b0;

    step();
    step();
    check_eq("drain", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
